conv_window_scheduler: RTL and testbench

Frame-level controller that sequences the shared SIZE×SIZE kernel compute datapath across an image. For each output pixel it fetches the clamped source window from frame memory and loads it into the compute block. It then pulses the compute block's start, waits for its done, and presents the filtered pixel with its coordinates on a ready/valid output stream. It sits between the frame SRAM read port and the downstream pixel writer.

---
 rtl/conv_sched_pkg.sv | 39 +++
 rtl/conv_addr_gen.sv | 52 +++++
 rtl/conv_window_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_sched_pkg
// Description : Shared types and helpers for the convolution window
//               scheduler: FSM state encoding, default window radius and
//               the border-replicating coordinate clamp.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_sched_pkg;

    // Default window edge; R is the radius for that default edge.
    localparam int SIZE_DEF = 3;
    localparam int R        = SIZE_DEF / 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT_RD = 3'd2,
        CONV    = 3'd3,
        WAIT_K  = 3'd4,
        EMIT    = 3'd5,
        DONE    = 3'd6
    } sched_state_t;

    // Replicate border pixels: pull a signed coordinate into [0, limit-1].
    function automatic int clamp_coord(input int value, input int limit);
        int result;
        if (value < 0) begin
            result = 0;
        end else if (value >= limit) begin
            result = limit - 1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_addr_gen
// Description : Combinational source-address generator. Offsets the output
//               pixel (x, y) by the window element (c-HALF, r-HALF), clamps
//               the result into the active image and forms sy*W_MAX + sx.
// Ports       : x, y          output pixel coordinate
//               r, c          window row / column index
//               img_w, img_h  active image dimensions (both >= 1 when used)
//               addr          SRAM word address
// Revision    : 1.0 - initial release
// ============================================================================
module conv_addr_gen
    import conv_sched_pkg::*;
#(
    parameter int SIZE  = 2 * R + 1,
    parameter int W_MAX = 64,
    parameter int H_MAX = 64,
    parameter int CW    = $clog2(((W_MAX > H_MAX) ? W_MAX : H_MAX) + 1),
    parameter int AW    = $clog2(W_MAX * H_MAX),
    parameter int IW    = $clog2(SIZE)
)(
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [IW-1:0] r,
    input  logic [IW-1:0] c,
    input  logic [CW-1:0] img_w,
    input  logic [CW-1:0] img_h,
    output logic [AW-1:0] addr
);

    localparam int HALF = SIZE / 2;

    // One extra sign bit keeps x+c-HALF from wrapping at the left/top edge.
    logic signed [CW:0] w_sx_raw;
    logic signed [CW:0] w_sy_raw;
    int                 w_sx;
    int                 w_sy;

    assign w_sx_raw = $signed({1'b0, x}) + $signed((CW+1)'(c)) - $signed((CW+1)'(HALF));
    assign w_sy_raw = $signed({1'b0, y}) + $signed((CW+1)'(r)) - $signed((CW+1)'(HALF));

    always_comb begin
        w_sx = clamp_coord(int'(w_sx_raw), int'(img_w));
        w_sy = clamp_coord(int'(w_sy_raw), int'(img_h));
    end

    // Row pitch is always W_MAX, independent of the active width.
    assign addr = AW'(w_sy * W_MAX + w_sx);

endmodule
`default_nettype wire

// File: rtl/conv_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_scheduler
// Description : Frame controller for a shared SIZE x SIZE kernel datapath.
//               For each output pixel it reads the clamped window one element
//               at a time, starts the compute block, waits for its result and
//               offers it on a ready/valid stream with its coordinates.
// Ports       : clk, n_rst               clock, async active-low reset
//               frame_start, img_w/h     frame request and dimensions
//               rd_en/rd_addr            SRAM read request (one outstanding)
//               rd_valid/rd_data         SRAM read return
//               win_matrix               window to compute block, [r][c]
//               kern_start/kern_done     compute handshake, kern_pixel result
//               out_valid/out_ready      output stream, out_pixel/out_x/out_y
//               busy, frame_done         status
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_scheduler
    import conv_sched_pkg::*;
#(
    parameter int SIZE  = 2 * R + 1,
    parameter int W_MAX = 64,
    parameter int H_MAX = 64,
    parameter int CW    = $clog2(((W_MAX > H_MAX) ? W_MAX : H_MAX) + 1),
    parameter int AW    = $clog2(W_MAX * H_MAX)
)(
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            frame_start,
    input  logic [CW-1:0]                   img_w,
    input  logic [CW-1:0]                   img_h,
    output logic                            rd_en,
    output logic [AW-1:0]                   rd_addr,
    input  logic                            rd_valid,
    input  logic [7:0]                      rd_data,
    output logic [SIZE-1:0][SIZE-1:0][7:0]  win_matrix,
    output logic                            kern_start,
    input  logic                            kern_done,
    input  logic [7:0]                      kern_pixel,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [7:0]                      out_pixel,
    output logic [CW-1:0]                   out_x,
    output logic [CW-1:0]                   out_y,
    output logic                            busy,
    output logic                            frame_done
);

    localparam int            IW       = $clog2(SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    sched_state_t  r_state;
    sched_state_t  w_next;
    logic [CW-1:0] r_w;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [IW-1:0] r_r;
    logic [IW-1:0] r_c;
    logic [AW-1:0] w_addr;
    logic          w_last_elem;
    logic          w_last_col;
    logic          w_last_pix;

    assign w_last_elem = (r_r == LAST_IDX) && (r_c == LAST_IDX);
    assign w_last_col  = (r_x == r_w - CW'(1));
    assign w_last_pix  = w_last_col && (r_y == r_h - CW'(1));

    conv_addr_gen #(
        .SIZE  (SIZE),
        .W_MAX (W_MAX),
        .H_MAX (H_MAX),
        .CW    (CW),
        .AW    (AW),
        .IW    (IW)
    ) u_addr_gen (
        .x     (r_x),
        .y     (r_y),
        .r     (r_r),
        .c     (r_c),
        .img_w (r_w),
        .img_h (r_h),
        .addr  (w_addr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Control outputs are decoded straight from the state so each pulse
    // lines up with the state that owns it.
    always_comb begin
        w_next     = r_state;
        rd_en      = 1'b0;
        rd_addr    = '0;
        kern_start = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_next = ((img_w == '0) || (img_h == '0)) ? DONE : FETCH;
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                rd_addr = w_addr;
                w_next  = WAIT_RD;
            end
            WAIT_RD: begin
                if (rd_valid) begin
                    w_next = w_last_elem ? CONV : FETCH;
                end
            end
            CONV: begin
                kern_start = 1'b1;
                w_next     = WAIT_K;
            end
            WAIT_K: begin
                if (kern_done) begin
                    w_next = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = w_last_pix ? DONE : FETCH;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                w_next     = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_w        <= '0;
            r_h        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_r        <= '0;
            r_c        <= '0;
            win_matrix <= '0;
            out_pixel  <= '0;
            out_x      <= '0;
            out_y      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_w <= img_w;
                        r_h <= img_h;
                        r_x <= '0;
                        r_y <= '0;
                        r_r <= '0;
                        r_c <= '0;
                    end
                end
                WAIT_RD: begin
                    if (rd_valid) begin
                        win_matrix[r_r][r_c] <= rd_data;
                        // Row-major walk; both indices return to 0 after
                        // the last element so the next pixel starts clean.
                        if (r_c == LAST_IDX) begin
                            r_c <= '0;
                            r_r <= (r_r == LAST_IDX) ? '0 : r_r + IW'(1);
                        end else begin
                            r_c <= r_c + IW'(1);
                        end
                    end
                end
                WAIT_K: begin
                    if (kern_done) begin
                        out_pixel <= kern_pixel;
                        out_x     <= r_x;
                        out_y     <= r_y;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (w_last_col) begin
                            r_x <= '0;
                            r_y <= r_y + CW'(1);
                        end else begin
                            r_x <= r_x + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_scheduler
// Description : Self-checking bench for conv_window_scheduler (SIZE=3,
//               64x64 frame store). SRAM and compute-block stubs, a window
//               reference model and an output scoreboard; table-driven
//               frames plus reset and randomized frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_scheduler;

    localparam int SZ = 3;
    localparam int CW = 7;
    localparam int AW = 12;

    logic                     clk = 1'b0;
    logic                     n_rst;
    logic                     frame_start;
    logic [CW-1:0]            img_w, img_h;
    logic                     rd_en;
    logic [AW-1:0]            rd_addr;
    logic                     rd_valid;
    logic [7:0]               rd_data;
    logic [SZ-1:0][SZ-1:0][7:0] win_matrix;
    logic                     kern_start, kern_done;
    logic [7:0]               kern_pixel;
    logic                     out_valid, out_ready;
    logic [7:0]               out_pixel;
    logic [CW-1:0]            out_x, out_y;
    logic                     busy, frame_done;

    conv_window_scheduler dut (
        .clk(clk), .n_rst(n_rst), .frame_start(frame_start),
        .img_w(img_w), .img_h(img_h), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .win_matrix(win_matrix),
        .kern_start(kern_start), .kern_done(kern_done), .kern_pixel(kern_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_x(out_x), .out_y(out_y), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w, h, rdlat, klat, rmode, kmode, imode, extra;
        int reads, outs, cycles, stall;
    } vec_t;
    typedef struct { int pix, x, y; } exp_t;

    logic [7:0] mem [0:4095];
    exp_t       exp_q [$];
    int         win_log [64][9];
    int n_cmp = 0, n_bad = 0;
    int n_reads, n_outs, stall_seen, stall_cnt, k_idx;
    int rd_lat_max = 1, k_lat = 1, ready_mode = 0, k_mode = 0;
    bit pend = 0;
    int p_pix, p_x, p_y;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compute-block behaviour: centre tap, or a position-weighted sum so that
    // any misplaced window element changes the result.
    function automatic int kfun(input int a[9], input int mode);
        int s = 0;
        if (mode == 0) return a[4];
        for (int i = 0; i < 9; i++) s += a[i] * (i + 1);
        return s & 255;
    endfunction

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 4096; i++) begin
            case (mode)
                0: mem[i] = 8'd10;
                1: mem[i] = 8'(((i / 64) * 4 + (i % 64)) & 255);
                default: mem[i] = 8'($urandom_range(255, 0));
            endcase
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_kern_start"}, kern_start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_win_zero"}, (win_matrix == '0) ? 1 : 0, 1);
        chk({tag, "_out_pixel"}, out_pixel, 0);
        chk({tag, "_out_x"}, out_x, 0);
        chk({tag, "_out_y"}, out_y, 0);
    endtask

    // SRAM: one outstanding read, return after 1..rd_lat_max cycles.
    initial begin : sram_model
        int a, lat;
        rd_valid = 1'b0;
        rd_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (rd_en) begin
                a   = int'(rd_addr);
                n_reads++;
                lat = int'($urandom_range(rd_lat_max, 1));
                repeat (lat) @(posedge clk);
                #1 rd_valid = 1'b1;
                rd_data = mem[a];
                @(posedge clk);
                #1 rd_valid = 1'b0;
            end
        end
    end

    // Compute block stub: snapshot the window at start, answer after k_lat.
    initial begin : kern_model
        int a[9];
        int d;
        kern_done  = 1'b0;
        kern_pixel = 8'd0;
        forever begin
            @(negedge clk);
            if (kern_start) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        a[r*3+c] = int'(win_matrix[r][c]);
                if (k_idx < 64) win_log[k_idx] = a;
                k_idx++;
                d = kfun(a, k_mode);
                repeat (k_lat) @(posedge clk);
                #1 kern_done = 1'b1;
                kern_pixel = 8'(d);
                @(posedge clk);
                #1 kern_done = 1'b0;
            end
        end
    end

    // Downstream ready: always, random, or a 5-cycle stall on output #2.
    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(2, 0) != 0);
                2: begin
                    if (out_valid && n_outs == 2 && stall_cnt < 5) begin
                        out_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output scoreboard and stream-protocol checks.
    initial begin : out_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                chk("no_read_while_valid", rd_en, 0);
                if (pend) begin
                    chk("hold_pixel", out_pixel, p_pix);
                    chk("hold_x", out_x, p_x);
                    chk("hold_y", out_y, p_y);
                end
                if (!out_ready) begin
                    stall_seen++;
                    pend  = 1;
                    p_pix = int'(out_pixel);
                    p_x   = int'(out_x);
                    p_y   = int'(out_y);
                end else begin
                    pend = 0;
                    n_outs++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pixel", out_pixel, e.pix);
                        chk("out_x", out_x, e.x);
                        chk("out_y", out_y, e.y);
                    end
                end
            end else begin
                if (pend) chk("valid_dropped", 0, 1);
                pend = 0;
            end
        end
    end

    task automatic run_frame(input vec_t v);
        int  cyc;
        bit  seen;
        int  a[9];
        int  sx, sy;
        rd_lat_max = v.rdlat; k_lat = v.klat; ready_mode = v.rmode; k_mode = v.kmode;
        n_reads = 0; n_outs = 0; stall_seen = 0; stall_cnt = 0; k_idx = 0; pend = 0;
        exp_q.delete();
        // Reference: every output pixel in raster order, window clamped to the image.
        for (int y = 0; y < v.h; y++) begin
            for (int x = 0; x < v.w; x++) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        sy = y + r - 1; sx = x + c - 1;
                        if (sy < 0) sy = 0;
                        if (sy > v.h - 1) sy = v.h - 1;
                        if (sx < 0) sx = 0;
                        if (sx > v.w - 1) sx = v.w - 1;
                        a[r*3+c] = int'(mem[sy*64+sx]);
                    end
                end
                exp_q.push_back('{kfun(a, v.kmode), x, y});
            end
        end
        @(posedge clk);
        #1 img_w = CW'(v.w); img_h = CW'(v.h); frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        cyc = 0; seen = 0;
        while (!seen && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("busy_rise", busy, 1);
            if (v.extra != 0 && cyc == 5) begin
                frame_start = 1'b1; img_w = CW'(1); img_h = CW'(1);
            end
            if (v.extra != 0 && cyc == 6) begin
                frame_start = 1'b0; img_w = CW'(v.w); img_h = CW'(v.h);
            end
            if (frame_done) seen = 1;
        end
        if (!seen) begin
            chk("frame_done_timeout", 0, 1);
            #1 n_rst = 1'b0;
            @(posedge clk);
            #1 n_rst = 1'b1;
            return;
        end
        if (v.cycles != 0) chk("frame_latency", cyc, v.cycles);
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 0);
        chk("busy_fall", busy, 0);
        repeat (4) begin
            @(negedge clk);
            if (frame_done) chk("extra_frame_done", 1, 0);
        end
        chk("read_count", n_reads, v.reads);
        chk("output_count", n_outs, v.outs);
        if (v.rmode != 1) chk("stall_cycles", stall_seen, v.stall);
    endtask

    vec_t vecs [6];
    vec_t rv;
    int   ew0 [9];
    int   ew7 [9];
    bit   found, noisy;

    initial begin : main
        //           w  h rdl kl rm km im ex reads outs cyc stall
        vecs[0] = '{3, 3, 1, 4, 0, 0, 0, 0, 81,   9, 217, 0};
        vecs[1] = '{4, 2, 1, 1, 0, 1, 1, 0, 72,   8, 169, 0};
        vecs[2] = '{3, 3, 1, 1, 2, 1, 2, 0, 81,   9, 195, 5};
        vecs[3] = '{2, 2, 1, 1, 0, 1, 2, 1, 36,   4,  85, 0};
        vecs[4] = '{0, 5, 1, 1, 0, 1, 2, 0,  0,   0,   1, 0};
        vecs[5] = '{1, 1, 1, 1, 0, 1, 2, 0,  9,   1,  22, 0};
        ew0 = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
        ew7 = '{2, 3, 3, 6, 7, 7, 6, 7, 7};

        n_rst = 1'b0; frame_start = 1'b0; img_w = '0; img_h = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            fill_mem(vecs[i].imode);
            run_frame(vecs[i]);
            if (i == 1) begin
                for (int j = 0; j < 9; j++) begin
                    chk("window_first_px", win_log[0][j], ew0[j]);
                    chk("window_last_px", win_log[7][j], ew7[j]);
                end
            end
        end

        // Reset while the compute block is working; its late done must be ignored.
        fill_mem(2);
        k_lat = 8; ready_mode = 0; k_mode = 1; rd_lat_max = 1;
        exp_q.delete(); pend = 0;
        @(posedge clk);
        #1 img_w = CW'(2); img_h = CW'(2); frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (kern_start) found = 1;
        end
        chk("kern_start_seen", found, 1);
        @(posedge clk);
        #1 n_rst = 1'b0;
        @(negedge clk);
        chk_reset("midreset");
        @(posedge clk);
        #1 n_rst = 1'b1;
        noisy = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid || busy || rd_en) noisy = 1;
        end
        chk("post_reset_quiet", noisy, 0);
        rv = '{2, 2, 1, 2, 0, 1, 2, 0, 36, 4, 89, 0};
        run_frame(rv);

        // Randomized frames: random image, latencies and back-pressure.
        for (int i = 0; i < 4; i++) begin
            rv.w = int'($urandom_range(6, 1));
            rv.h = int'($urandom_range(4, 1));
            rv.rdlat = 3;
            rv.klat = int'($urandom_range(3, 1));
            rv.rmode = 1; rv.kmode = 1; rv.imode = 2; rv.extra = 0;
            rv.reads = rv.w * rv.h * 9;
            rv.outs = rv.w * rv.h;
            rv.cycles = 0; rv.stall = 0;
            fill_mem(2);
            run_frame(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
